// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown register with one-second prescaler.
// Loads a preset, counts down while running, flags expiry at 00:00.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] time_out,
  output logic        running,
  output logic        done,
  output logic        expired,
  output logic        load_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   dec;
  logic          valid;
  logic          tick;

  assign valid = (preset[15:12] <= 4'd9) &&
                 (preset[11:8]  <= 4'd9) &&
                 (preset[7:4]   <= 4'd5) &&
                 (preset[3:0]   <= 4'd9);

  assign tick = (state == RUN) && (presc == LAST);

  // Ripple-borrow decrement; 0000 is never fed in.
  always_comb begin
    dec = time_out;
    if (time_out[3:0] != 4'd0) begin
      dec[3:0] = time_out[3:0] - 4'd1;
    end else begin
      dec[3:0] = 4'd9;
      if (time_out[7:4] != 4'd0) begin
        dec[7:4] = time_out[7:4] - 4'd1;
      end else begin
        dec[7:4] = 4'd5;
        if (time_out[11:8] != 4'd0) begin
          dec[11:8] = time_out[11:8] - 4'd1;
        end else begin
          dec[11:8]  = 4'd9;
          dec[15:12] = time_out[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      time_out <= 16'h0000;
      running  <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (valid) begin
          time_out <= preset;
          presc    <= '0;
          state    <= IDLE;
          running  <= 1'b0;
          expired  <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (tick) begin
              presc    <= '0;
              time_out <= dec;
            end else begin
              presc <= presc + 1'b1;
            end
            if (tick && dec == 16'h0000) begin
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
              done    <= 1'b1;
            end else if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          IDLE: begin
            if (start && !pause) begin
              if (time_out != 16'h0000) begin
                state   <= RUN;
                running <= 1'b1;
                presc   <= '0;
              end else begin
                state   <= EXPIRED;
                expired <= 1'b1;
                done    <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (start && !pause && time_out != 16'h0000) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Countdown register for the minutes:seconds timer path. It loads the 16-bit BCD preset word produced by the add/sub digit-adder stage and decrements it once per second while running. It drives the current time back as the adder's input word and flags expiry at 00:00.

## Interface
- TICK_DIV, 50_000_000, clock cycles per one-second tick (≥2; benches use 4)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  pulse; latch `preset` into the time register
- preset  in  16  BCD {min_tens[15:12], min_ones[11:8], sec_tens[7:4], sec_ones[3:0]}
- start  in  1  pulse; begin or resume counting
- pause  in  1  pulse; suspend counting
- time_out  out  16  current BCD time, same packing as `preset`; feeds the adder input word
- running  out  1  high in RUN
- done  out  1  one-cycle pulse when the count reaches 0000
- expired  out  1  level, high in EXPIRED
- load_err  out  1  one-cycle pulse when a `load` is rejected

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. Reset → IDLE, time_out=16'h0000, prescaler=0, and running, done, expired, load_err all 0.
- Command priority when several are asserted in the same cycle: load > pause > start.
- Load validity: every digit ≤9 and sec_tens ≤5.
  - Valid load in any state: time_out←preset, prescaler←0, state→IDLE.
  - Invalid load: load_err pulses; time_out, state and prescaler are unchanged.
- start:
  - From IDLE or PAUSED with time_out≠0000: →RUN. From IDLE, prescaler←0. From PAUSED, the prescaler value is kept.
  - From IDLE with time_out=0000: →EXPIRED, done pulses.
  - In RUN or EXPIRED: ignored.
- pause: RUN→PAUSED, prescaler frozen. Ignored in other states.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick = (prescaler==TICK_DIV-1) in RUN. On tick the prescaler wraps to 0.
- BCD decrement on tick, ripple-borrow:
  - sec_ones: 0→9 with borrow, else −1.
  - sec_tens on borrow: 0→5 with borrow, else −1.
  - min_ones on borrow: 0→9 with borrow, else −1.
  - min_tens on borrow: −1. It cannot underflow because 0000 is never decremented.
- Expiry: if the decrement result is 0000, then time_out←0000, state→EXPIRED and done pulses, all on the same edge. EXPIRED holds until a valid load or reset. start and pause are ignored in EXPIRED.
- time_out is always a registered value with no combinational path from inputs. An out-of-range value is never produced.

## Timing
- All commands take effect on the clk edge where they are sampled. Outputs reflect the change one cycle later, i.e. the cycle after the edge.
- First decrement after start from IDLE happens TICK_DIV cycles after the start edge. Subsequent decrements occur every TICK_DIV cycles.
- Pause/resume preserves phase: the total RUN cycles between decrements is always TICK_DIV.
- done is high for exactly one cycle and coincides with the first cycle of expired=1.
- load in the same cycle as a tick: load wins and the tick is discarded.
- rst_n assertion is asynchronous and takes effect mid-count. Deassertion is sampled on clk. The first command is accepted on the first edge after release.

## Test plan
- **Reset and load.** Reset, then load 16'h0130 → time_out=0130, IDLE, running=0. Then apply no start for 20 cycles → time_out stays 0130.
- **Borrow chain** (TICK_DIV=4). Load 1000, start → after 4 cycles time_out=0959, after 8 cycles 0958. Load 0100, start, one tick → 0059.
- **Expiry.** Load 0002, start → 0001 at +4 cycles, then 0000 at +8 with a single-cycle done and expired held high. start pulses afterwards → no change. Load 0005 → expired=0, IDLE.
- **Pause phase.** Load 0010, start, pause after 2 RUN cycles, wait 10 cycles, start → decrement to 0009 occurs exactly 2 RUN cycles after resume.
- **Invalid load and priority.**
  - Load 16'h0060 → load_err pulse, time_out unchanged.
  - Load 16'h0A00 → load_err pulse, time_out unchanged.
  - load and start in the same cycle → IDLE with new value, running=0.
  - pause and start in the same cycle while RUN → PAUSED.
- **Reset mid-count.** Load 0030, start, drop rst_n during RUN → time_out=0000, state IDLE immediately. Load 0000 then start → done pulse, EXPIRED.
